// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-to-APB bridge: transfer types, FSM states,
// the bridge address window and the slave-select field position.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [31:0] ADDR_BASE  = 32'h8000_0000;
    localparam logic [31:0] ADDR_LIMIT = 32'h8FFF_FFFF;

    // Haddr[SLV_SEL_MSB:SLV_SEL_LSB] picks one of four 64 MB slave windows
    localparam int SLV_SEL_MSB = 27;
    localparam int SLV_SEL_LSB = 26;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WWAIT   = 3'd1,
        ST_WRITE   = 3'd2,
        ST_WENABLE = 3'd3,
        ST_READ    = 3'd4,
        ST_RENABLE = 3'd5
    } state_t;

    // One-hot slave select from the two window bits
    function automatic logic [3:0] sel_decode(input logic [1:0] win);
        return 4'b0001 << win;
    endfunction

endpackage

// File: rtl/ahb_slave_decode.sv
// Address-phase qualification, slave decode and the address/write/data
// pipeline registers feeding the bridge FSM.
module ahb_slave_decode
    import ahb_apb_pkg::*;
(
    input  logic        clk,
    input  logic        Hrstn,
    input  logic        i_sample,     // FSM is in a state that accepts an address phase
    input  logic        i_wdata_en,   // FSM is in the write data phase
    input  logic        i_hwrite,
    input  logic        i_hreadyin,
    input  logic [1:0]  i_htrans,
    input  logic [31:0] i_haddr,
    input  logic [31:0] i_hwdata,
    output logic        o_valid,
    output logic [3:0]  o_sel_dec,
    output logic [31:0] o_addr_q,
    output logic [3:0]  o_sel_q,
    output logic        o_write_q,
    output logic [31:0] o_wdata_q
);

    logic        w_active;
    logic        w_in_range;
    logic [31:0] r_addr;
    logic [3:0]  r_sel;
    logic        r_write;
    logic [31:0] r_wdata;

    // Qualify the current address phase and decode its slave window
    always_comb begin
        w_active   = (i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ);
        w_in_range = (i_haddr >= ADDR_BASE) && (i_haddr <= ADDR_LIMIT);
        o_valid    = i_hreadyin && w_active && w_in_range;
        o_sel_dec  = o_valid ? sel_decode(i_haddr[SLV_SEL_MSB:SLV_SEL_LSB]) : 4'b0000;
    end

    // Capture address, direction and select at the end of an accepted address phase
    always_ff @(posedge clk or negedge Hrstn) begin
        if (!Hrstn) begin
            r_addr  <= 32'h0;
            r_sel   <= 4'b0000;
            r_write <= 1'b0;
        end else if (i_sample && o_valid) begin
            r_addr  <= i_haddr;
            r_sel   <= o_sel_dec;
            r_write <= i_hwrite;
        end
    end

    // Capture write data during the write data phase; doubles as the Pwdata register
    always_ff @(posedge clk or negedge Hrstn) begin
        if (!Hrstn) begin
            r_wdata <= 32'h0;
        end else if (i_wdata_en) begin
            r_wdata <= i_hwdata;
        end
    end

    assign o_addr_q  = r_addr;
    assign o_sel_q   = r_sel;
    assign o_write_q = r_write;
    assign o_wdata_q = r_wdata;

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-to-APB bridge: transfer FSM plus registered APB outputs.
// Handshake: the master may present a new address phase only while
// Hreadyout is 1 (IDLE/WENABLE/RENABLE); Hreadyout is 0 in every other state.
module ahb_apb_bridge
    import ahb_apb_pkg::*;
(
    input  logic        clk,
    input  logic        Hrstn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata,
    output logic [3:0]  Psel,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic [2:0]  o_dbg_state
);

    state_t      r_state;
    state_t      w_next;
    logic        w_sample;
    logic        w_valid;
    logic [3:0]  w_sel_dec;
    logic [31:0] w_addr_q;
    logic [3:0]  w_sel_q;
    logic        w_write_q;

    assign w_sample = (r_state == ST_IDLE) || (r_state == ST_WENABLE) ||
                      (r_state == ST_RENABLE);

    ahb_slave_decode u_decode (
        .clk        (clk),
        .Hrstn      (Hrstn),
        .i_sample   (w_sample),
        .i_wdata_en (r_state == ST_WWAIT),
        .i_hwrite   (Hwrite),
        .i_hreadyin (Hreadyin),
        .i_htrans   (Htrans),
        .i_haddr    (Haddr),
        .i_hwdata   (Hwdata),
        .o_valid    (w_valid),
        .o_sel_dec  (w_sel_dec),
        .o_addr_q   (w_addr_q),
        .o_sel_q    (w_sel_q),
        .o_write_q  (w_write_q),
        .o_wdata_q  (Pwdata)
    );

    // State register
    always_ff @(posedge clk or negedge Hrstn) begin
        if (!Hrstn) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: idle and enable states accept a new address phase
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_WENABLE, ST_RENABLE: begin
                if (w_valid) w_next = Hwrite ? ST_WWAIT : ST_READ;
                else         w_next = ST_IDLE;
            end
            ST_WWAIT: w_next = ST_WRITE;
            ST_WRITE: w_next = ST_WENABLE;
            ST_READ:  w_next = ST_RENABLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // APB outputs, registered from the next state so they change only on clock edges.
    // A read launched straight out of an enable state keeps Psel low in its setup
    // cycle, so consecutive transfers are always separated by one deselected cycle.
    always_ff @(posedge clk or negedge Hrstn) begin
        if (!Hrstn) begin
            Psel    <= 4'b0000;
            Penable <= 1'b0;
            Pwrite  <= 1'b0;
            Paddr   <= 32'h0;
        end else begin
            case (w_next)
                ST_READ: begin
                    Psel    <= (r_state == ST_IDLE) ? w_sel_dec : 4'b0000;
                    Penable <= 1'b0;
                    Pwrite  <= 1'b0;
                    Paddr   <= Haddr;
                end
                ST_WRITE: begin
                    Psel    <= w_sel_q;
                    Penable <= 1'b0;
                    Pwrite  <= w_write_q;
                    Paddr   <= w_addr_q;
                end
                ST_WENABLE, ST_RENABLE: begin
                    Psel    <= w_sel_q;
                    Penable <= 1'b1;
                end
                default: begin
                    Psel    <= 4'b0000;
                    Penable <= 1'b0;
                end
            endcase
        end
    end

    assign Hreadyout   = w_sample;
    assign Hresp       = 2'b00;
    assign Hrdata      = (r_state == ST_RENABLE) ? Prdata : 32'h0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: stimulus pushes the expected APB access
// into exp_q; a negedge monitor pops and compares at every APB access phase.
module tb_ahb_apb_bridge;
  import ahb_apb_pkg::*;

  logic        clk;
  logic        Hrstn;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [3:0]  Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [2:0]  o_dbg_state;

  // {Psel, Pwrite, Paddr, data} where data is Pwdata for writes, Hrdata for reads
  logic [68:0] exp_q[$];
  logic [68:0] mon_e;
  int          checks;
  int          errors;

  ahb_apb_bridge dut (
    .clk         (clk),
    .Hrstn       (Hrstn),
    .Hwrite      (Hwrite),
    .Hreadyin    (Hreadyin),
    .Htrans      (Htrans),
    .Haddr       (Haddr),
    .Hwdata      (Hwdata),
    .Prdata      (Prdata),
    .Hreadyout   (Hreadyout),
    .Hresp       (Hresp),
    .Hrdata      (Hrdata),
    .Psel        (Psel),
    .Penable     (Penable),
    .Pwrite      (Pwrite),
    .Paddr       (Paddr),
    .Pwdata      (Pwdata),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Address phase; returns #1 after the edge that sampled it, data phase driven
  task automatic addr_phase(input logic wr, input logic [1:0] trans, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] exp_sel,
                            input logic expect_xfer);
    Hwrite   = wr;
    Htrans   = trans;
    Haddr    = addr;
    Hreadyin = 1'b1;
    if (expect_xfer) exp_q.push_back({exp_sel, wr, addr, data});
    @(posedge clk); #1;
    Htrans = HTRANS_IDLE;
    if (wr) Hwdata = data;
    else    Prdata = data;
  endtask

  // Wait (bounded) until Hreadyout rises; checks the number of stall cycles seen
  task automatic wait_done(input int exp_stall, input string name);
    int cnt;
    cnt = 0;
    while (!Hreadyout && cnt < 8) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(name, cnt, exp_stall);
  endtask

  task automatic idle_cycle();
    Htrans = HTRANS_IDLE;
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (Hrstn && Psel != 4'b0000 && Penable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_apb_access", {Psel, Paddr}, 36'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("apb_access", {Psel, Pwrite, Paddr, (Pwrite ? Pwdata : Hrdata)}, mon_e);
        check("access_hreadyout", Hreadyout, 1'b1);
        check("access_hresp", Hresp, 2'b00);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    Hrstn    = 1'b0;
    Hwrite   = 1'b0;
    Hreadyin = 1'b1;
    Htrans   = HTRANS_IDLE;
    Haddr    = 32'h0;
    Hwdata   = 32'h0;
    Prdata   = 32'h0;

    #3;
    check("reset_outputs", {Hreadyout, Hresp, Hrdata, Psel, Penable, Pwrite, Paddr, Pwdata},
          {1'b1, 2'b00, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0});
    check("reset_state", o_dbg_state, ST_IDLE);
    @(posedge clk); #1;
    Hrstn = 1'b1;
    idle_cycle();

    // Single write
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0001, 1'b1);
    check("wr_wwait", {Psel, Penable, Hreadyout}, {4'b0000, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("wr_setup", {Psel, Penable, Pwrite, Paddr, Pwdata, Hreadyout},
          {4'b0001, 1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0});
    wait_done(1, "wr_enable_latency");
    idle_cycle();
    check("idle_hold", {Psel, Penable, Pwrite, Paddr, Pwdata, Hreadyout},
          {4'b0000, 1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1});

    // Single read
    addr_phase(1'b0, HTRANS_NONSEQ, 32'h8C00_0004, 32'h1234_5678, 4'b1000, 1'b1);
    check("rd_setup", {Psel, Penable, Pwrite, Paddr, Hreadyout, Hrdata},
          {4'b1000, 1'b0, 1'b0, 32'h8C00_0004, 1'b0, 32'h0});
    wait_done(1, "rd_latency");
    idle_cycle();
    check("rd_idle_hrdata", Hrdata, 32'h0);

    // Back-to-back reads
    addr_phase(1'b0, HTRANS_NONSEQ, 32'h8400_0000, 32'hA5A5_0001, 4'b0010, 1'b1);
    wait_done(1, "b2b_rd1_latency");
    addr_phase(1'b0, HTRANS_SEQ, 32'h8400_0004, 32'hA5A5_0002, 4'b0010, 1'b1);
    check("b2b_rd_gap", {Psel, Penable, Paddr}, {4'b0000, 1'b0, 32'h8400_0004});
    wait_done(1, "b2b_rd2_latency");
    idle_cycle();

    // Write then read back-to-back, top of the bridge window
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h8000_0100, 32'h1111_2222, 4'b0001, 1'b1);
    wait_done(2, "b2b_wr_latency");
    addr_phase(1'b0, HTRANS_NONSEQ, 32'h8FFF_FFFC, 32'hCAFE_F00D, 4'b1000, 1'b1);
    check("b2b_wr_rd_gap", {Psel, Penable}, {4'b0000, 1'b0});
    wait_done(1, "b2b_rd_latency");
    idle_cycle();

    // Ignored address phases
    addr_phase(1'b0, HTRANS_NONSEQ, 32'h9000_0000, 32'h0, 4'b0000, 1'b0);
    check("ign_above_range", {Psel, Penable, Hreadyout, Hresp}, {4'b0000, 1'b0, 1'b1, 2'b00});
    addr_phase(1'b1, HTRANS_BUSY, 32'h8000_0000, 32'h0, 4'b0000, 1'b0);
    check("ign_busy", {Psel, Penable, Hreadyout, Hresp}, {4'b0000, 1'b0, 1'b1, 2'b00});
    addr_phase(1'b0, HTRANS_SEQ, 32'h7FFF_FFFC, 32'h0, 4'b0000, 1'b0);
    check("ign_below_range", {Psel, Penable, Hreadyout, o_dbg_state},
          {4'b0000, 1'b0, 1'b1, ST_IDLE});
    Hreadyin = 1'b0;
    Htrans   = HTRANS_NONSEQ;
    Haddr    = 32'h8000_0000;
    @(posedge clk); #1;
    check("ign_hreadyin_low", {Psel, Penable, Hreadyout, o_dbg_state},
          {4'b0000, 1'b0, 1'b1, ST_IDLE});
    Hreadyin = 1'b1;
    idle_cycle();

    // Reset mid-write abandons the transfer
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h8000_0020, 32'h55AA_55AA, 4'b0001, 1'b1);
    @(posedge clk); #1;
    check("pre_reset_state", o_dbg_state, ST_WRITE);
    #2;
    Hrstn = 1'b0;
    #1;
    check("midreset_outputs", {Hreadyout, Hresp, Hrdata, Psel, Penable, Pwrite, Paddr, Pwdata},
          {1'b1, 2'b00, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0});
    check("midreset_state", o_dbg_state, ST_IDLE);
    exp_q.delete();
    @(posedge clk); #1;
    Hrstn = 1'b1;
    idle_cycle();
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h8800_0000, 32'h0BAD_F00D, 4'b0100, 1'b1);
    wait_done(2, "post_reset_wr_latency");
    idle_cycle();
    idle_cycle();

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; ports named as in the codebase.
REQ-002 clk  input  1  bridge clock, all state on rising edge.
REQ-003 Hrstn  input  1  asynchronous active-low reset.
REQ-004 Hwrite  input  1  AHB direction (1 = write), address phase.
REQ-005 Hreadyin  input  1  AHB system HREADY; address accepted only when high.
REQ-006 Htrans  input  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 Haddr  input  32  AHB address, address phase.
REQ-008 Hwdata  input  32  AHB write data, data phase.
REQ-009 Prdata  input  32  APB read data from the selected slave.
REQ-010 Hreadyout  output  1  bridge ready to the AHB master.
REQ-011 Hresp  output  2  AHB response; constant 00 (OKAY).
REQ-012 Hrdata  output  32  AHB read data.
REQ-013 Psel  output  4  one-hot APB slave select.
REQ-014 Penable  output  1  APB enable (access phase).
REQ-015 Pwrite  output  1  APB direction.
REQ-016 Paddr, Pwdata  output  32 each  APB address / write data.

Function
REQ-017 valid SHALL be Hreadyin & Htrans in {NONSEQ, SEQ} & Haddr in 0x8000_0000..0x8FFF_FFFF; BUSY, IDLE or out-of-range accesses are ignored, with no APB activity and Hresp OKAY.
REQ-018 Decode SHALL use Haddr[27:26] when valid: 00 -> Psel 0001, 01 -> 0010, 10 -> 0100, 11 -> 1000.
REQ-019 On valid, the address, Hwrite and decoded select SHALL be registered at the end of the address-phase cycle.
REQ-020 FSM states SHALL be ST_IDLE, ST_WWAIT, ST_WRITE, ST_WENABLE, ST_READ, ST_RENABLE.
REQ-021 ST_IDLE: valid & Hwrite -> ST_WWAIT; valid & !Hwrite -> ST_READ; otherwise stay.
REQ-022 ST_WWAIT SHALL latch Hwdata, then go to ST_WRITE; ST_WRITE SHALL go to ST_WENABLE; ST_READ SHALL go to ST_RENABLE.
REQ-023 ST_WENABLE/ST_RENABLE SHALL sample a new address phase: valid & Hwrite -> ST_WWAIT; valid & !Hwrite -> ST_READ; otherwise ST_IDLE.
REQ-024 Hreadyout SHALL be 1 in ST_IDLE, ST_WENABLE and ST_RENABLE, and 0 in ST_WWAIT, ST_WRITE and ST_READ.
REQ-025 Setup states (ST_WRITE, ST_READ) SHALL drive Psel = latched select, Penable = 0, Paddr = latched address, and Pwrite = 1 (write) or 0 (read); enable states SHALL hold these values with Penable = 1.
REQ-026 Pwdata SHALL hold the latched Hwdata from ST_WRITE through ST_WENABLE.
REQ-027 Outside the setup and enable states, Psel = 0 and Penable = 0; Paddr, Pwdata and Pwrite hold their last values.
REQ-028 Hrdata SHALL equal Prdata combinationally in ST_RENABLE and 0 otherwise.
REQ-029 Latency: read data is returned 2 cycles after the address-phase edge; a write completes (Hreadyout = 1 with Penable = 1) 3 cycles after the address-phase edge.
REQ-030 Back-to-back: a valid transfer in an enable state SHALL start with no idle cycle, and Psel SHALL drop for exactly the intermediate WWAIT/READ cycle.
REQ-031 APB outputs SHALL be registered and glitch-free; Hresp SHALL never be non-zero.

Reset
REQ-032 Hrstn low SHALL immediately force ST_IDLE, Hreadyout = 1, and Hresp, Hrdata, Psel, Penable, Pwrite, Paddr, Pwdata and all latches to 0.
REQ-033 Reset asserted mid-transfer SHALL abandon it; after release, the first valid address SHALL start a fresh transfer.

Structure
REQ-034 Package ahb_apb_pkg SHALL hold the Htrans encodings, the FSM state enum, and the address base/limit and slave-window constants.
REQ-035 Sub-module ahb_slave_decode SHALL hold the valid logic, Psel decode and address/write/data pipeline registers; ahb_apb_bridge holds the FSM and APB output registers.

Verification
REQ-036 Single write, Haddr 0x8000_0010 NONSEQ, Hwdata 0xDEAD_BEEF -> Psel 0001, Paddr 0x8000_0010, Pwdata 0xDEAD_BEEF, Pwrite 1, Penable high at +3 cycles, Hreadyout 0 for 2 cycles.
REQ-037 Single read, Haddr 0x8C00_0004, Prdata 0x1234_5678 -> Psel 1000, Penable at +2 cycles, Hrdata 0x1234_5678 with Hreadyout 1.
REQ-038 Back-to-back SEQ reads at 0x8400_0000 then 0x8400_0004 -> two APB transfers, Psel 0010, exactly one Psel-low cycle between them.
REQ-039 Haddr 0x9000_0000 NONSEQ, or Htrans BUSY at 0x8000_0000 -> no Psel, Hreadyout stays 1, Hresp 00.
REQ-040 Hrstn pulsed low during ST_WRITE -> all outputs at reset values within the same cycle; a subsequent write to 0x8800_0000 completes normally with Psel 0100.
